// File: rtl/alu_ctrl_fsm.sv
// Control FSM for the alu: fetch 16-bit instr, decode to alu controls, keep the PSR, resolve branches.
// Latency: 3 cycles per instruction (FETCH -> DECODE -> EXECUTE), strobes pulse once in EXECUTE.
// Backpressure: FETCH holds with fetch_req_o high until instr_valid_i is seen; no other stalls.
module alu_ctrl_fsm #(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic              instr_valid_i,
  input  logic [FLAG_W-1:0] alu_flags_i,
  output logic              fetch_req_o,
  output logic [3:0]        alu_opcode_o,
  output logic              alu_cin_o,
  output logic              a_zero_o,
  output logic [3:0]        rdest_addr_o,
  output logic [3:0]        rsrc_addr_o,
  output logic              imm_sel_o,
  output logic [DATA_W-1:0] imm_out_o,
  output logic              reg_we_o,
  output logic              pc_inc_o,
  output logic              pc_branch_o,
  output logic [DATA_W-1:0] branch_disp_o,
  output logic [FLAG_W-1:0] psr_o
);

  // PSR bit positions {Z,C,O,L,N}
  localparam int PSR_Z = 4;
  localparam int PSR_C = 3;
  localparam int PSR_O = 2;
  localparam int PSR_L = 1;
  localparam int PSR_N = 0;

  // Primary opcodes / reg-form extensions (alu opcode encoding shares these values)
  localparam logic [3:0] OP_REG  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_LSH  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_ADDU = 4'b0110;
  localparam logic [3:0] OP_ADDC = 4'b0111;
  localparam logic [3:0] OP_SHFT = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_SUBC = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_BCND = 4'b1100;
  localparam logic [3:0] OP_ASHU = 4'b1100;
  localparam logic [3:0] OP_MOVI = 4'b1101;
  localparam logic [3:0] EXT_MOV = 4'b1101;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [FLAG_W-1:0] psr_q, psr_d;

  logic [3:0]        ir_op, ir_ext, ir_cond;
  logic [DATA_W-1:0] sext8, zext8, sext4;

  logic [3:0]        dec_op;
  logic              dec_isel, dec_az, dec_we, dec_arith, dec_cmp, dec_br;
  logic [DATA_W-1:0] dec_imm;
  logic              br_taken;
  logic              in_exec;

  assign ir_op   = ir_q[15:12];
  assign ir_cond = ir_q[11:8];
  assign ir_ext  = ir_q[7:4];
  assign sext8   = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign zext8   = {{(DATA_W-8){1'b0}}, ir_q[7:0]};
  assign sext4   = {{(DATA_W-4){ir_q[3]}}, ir_q[3:0]};

  // Instruction decode from IR; anything unrecognised falls through as a NOP
  always_comb begin
    dec_op    = 4'b0000;
    dec_isel  = 1'b0;
    dec_az    = 1'b0;
    dec_we    = 1'b0;
    dec_arith = 1'b0;
    dec_cmp   = 1'b0;
    dec_br    = 1'b0;
    dec_imm   = '0;
    case (ir_op)
      OP_REG: begin
        case (ir_ext)
          OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
            dec_op    = ir_ext;
            dec_we    = 1'b1;
            dec_arith = 1'b1;
          end
          OP_CMP: begin
            dec_op  = ir_ext;
            dec_cmp = 1'b1;
          end
          OP_ADDU, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            dec_op = ir_ext;
            dec_we = 1'b1;
          end
          EXT_MOV: begin
            // MOV is ADDU with the A operand forced to zero
            dec_op = OP_ADDU;
            dec_az = 1'b1;
            dec_we = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
        dec_op    = ir_op;
        dec_isel  = 1'b1;
        dec_imm   = sext8;
        dec_we    = 1'b1;
        dec_arith = 1'b1;
      end
      OP_CMP: begin
        dec_op   = ir_op;
        dec_isel = 1'b1;
        dec_imm  = sext8;
        dec_cmp  = 1'b1;
      end
      OP_ADDU, OP_AND, OP_OR, OP_XOR: begin
        // logical/unsigned immediates are zero-extended
        dec_op   = ir_op;
        dec_isel = 1'b1;
        dec_imm  = zext8;
        dec_we   = 1'b1;
      end
      OP_MOVI: begin
        dec_op   = OP_ADDU;
        dec_az   = 1'b1;
        dec_isel = 1'b1;
        dec_imm  = sext8;
        dec_we   = 1'b1;
      end
      OP_SHFT: begin
        case (ir_ext)
          4'b0100: begin
            dec_op = OP_LSH;
            dec_we = 1'b1;
          end
          4'b1100: begin
            dec_op = OP_ASHU;
            dec_we = 1'b1;
          end
          4'b0000: begin
            dec_op   = OP_LSH;
            dec_isel = 1'b1;
            dec_imm  = sext4;
            dec_we   = 1'b1;
          end
          4'b0001: begin
            dec_op   = OP_ASHU;
            dec_isel = 1'b1;
            dec_imm  = sext4;
            dec_we   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_BCND: dec_br = 1'b1;
      default: ;
    endcase
  end

  // Branch condition evaluated against the registered PSR
  always_comb begin
    br_taken = 1'b0;
    case (ir_cond)
      4'h0: br_taken =  psr_q[PSR_Z];
      4'h1: br_taken = ~psr_q[PSR_Z];
      4'h2: br_taken =  psr_q[PSR_C];
      4'h3: br_taken = ~psr_q[PSR_C];
      4'h4: br_taken =  psr_q[PSR_L];
      4'h5: br_taken = ~psr_q[PSR_L];
      4'h6: br_taken =  psr_q[PSR_N];
      4'h7: br_taken = ~psr_q[PSR_N];
      4'h8: br_taken =  psr_q[PSR_O];
      4'h9: br_taken = ~psr_q[PSR_O];
      4'hA: br_taken = ~psr_q[PSR_L] & ~psr_q[PSR_Z];
      4'hB: br_taken =  psr_q[PSR_L] |  psr_q[PSR_Z];
      4'hC: br_taken = ~psr_q[PSR_N] & ~psr_q[PSR_Z];
      4'hD: br_taken =  psr_q[PSR_N] |  psr_q[PSR_Z];
      4'hE: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  // Next state, IR capture and PSR update
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    psr_d   = psr_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid_i) begin
          ir_d    = instr_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_FETCH;
        if (dec_arith) begin
          psr_d[PSR_C] = alu_flags_i[PSR_C];
          psr_d[PSR_O] = alu_flags_i[PSR_O];
        end
        if (dec_cmp) begin
          psr_d[PSR_Z] = alu_flags_i[PSR_Z];
          psr_d[PSR_L] = alu_flags_i[PSR_L];
          psr_d[PSR_N] = alu_flags_i[PSR_N];
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, IR and PSR registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      psr_q   <= psr_d;
    end
  end

  // Strobes only in EXECUTE; reset kills them combinationally so a mid-EXECUTE reset has no effect
  assign in_exec = (state_q == S_EXECUTE) && !reset_i;

  // Output drive: datapath selects follow IR, strobes gated by EXECUTE
  always_comb begin
    fetch_req_o   = (state_q == S_FETCH);
    alu_opcode_o  = reset_i ? 4'b0000 : dec_op;
    alu_cin_o     = psr_q[PSR_C];
    a_zero_o      = dec_az;
    rdest_addr_o  = ir_q[11:8];
    rsrc_addr_o   = ir_q[3:0];
    imm_sel_o     = dec_isel;
    imm_out_o     = dec_imm;
    branch_disp_o = sext8;
    psr_o         = psr_q;
    reg_we_o      = in_exec & dec_we;
    pc_branch_o   = in_exec & dec_br & br_taken;
    pc_inc_o      = in_exec & ~(dec_br & br_taken);
  end

endmodule
